// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 640x480@60 raster timing constants and helpers
package vga_pkg;

  localparam int H_ACTIVE        = 640;
  localparam int H_FRONT         = 16;
  localparam int H_SYNC          = 96;
  localparam int H_BACK          = 48;
  localparam int V_ACTIVE        = 480;
  localparam int V_FRONT         = 10;
  localparam int V_SYNC          = 2;
  localparam int V_BACK          = 33;
  localparam int SYNC_ACTIVE_LOW = 1;

  localparam int CNT_W           = 10;
  localparam int CNT_LIMIT       = 1 << CNT_W;

  typedef struct packed {
    logic valid;
    logic hsync;
    logic vsync;
    logic frame_start;
  } vga_ctl_t;

  // Half-open window test [lo, hi) on an unsigned counter value.
  function automatic logic in_window(input logic [CNT_W-1:0] value,
                                     input int lo, input int hi);
    int v;
    v = int'(value);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// rtl/wrap_counter.sv - enabled up-counter that wraps to zero after TERMINAL
module wrap_counter #(
  parameter int WIDTH    = 10,
  parameter int TERMINAL = 799
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count,
  output logic [WIDTH-1:0] o_count_next,
  output logic             o_wrap
);

  localparam logic [WIDTH-1:0] TERM = WIDTH'(TERMINAL);

  logic [WIDTH-1:0] r_count;
  logic             w_at_term;

  assign w_at_term = (r_count == TERM);
  assign o_wrap    = i_en && w_at_term;
  assign o_count   = r_count;

  // The next value is exported so the parent can register decodes in step with the count.
  always_comb begin
    o_count_next = r_count;
    if (i_en) begin
      o_count_next = w_at_term ? '0 : r_count + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      r_count <= o_count_next;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - free-running VGA raster counters with registered sync/valid decode
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE        = vga_pkg::H_ACTIVE,
  parameter int H_FRONT         = vga_pkg::H_FRONT,
  parameter int H_SYNC          = vga_pkg::H_SYNC,
  parameter int H_BACK          = vga_pkg::H_BACK,
  parameter int V_ACTIVE        = vga_pkg::V_ACTIVE,
  parameter int V_FRONT         = vga_pkg::V_FRONT,
  parameter int V_SYNC          = vga_pkg::V_SYNC,
  parameter int V_BACK          = vga_pkg::V_BACK,
  parameter int SYNC_ACTIVE_LOW = vga_pkg::SYNC_ACTIVE_LOW
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             valid,
  output logic [CNT_W-1:0] col,
  output logic [CNT_W-1:0] row,
  output logic             hsync,
  output logic             vsync,
  output logic             frame_start
);

  localparam int   H_TOTAL   = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int   V_TOTAL   = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int   H_SYNC_LO = H_ACTIVE + H_FRONT;
  localparam int   H_SYNC_HI = H_ACTIVE + H_FRONT + H_SYNC;
  localparam int   V_SYNC_LO = V_ACTIVE + V_FRONT;
  localparam int   V_SYNC_HI = V_ACTIVE + V_FRONT + V_SYNC;
  localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

  if (H_TOTAL > CNT_LIMIT) begin : g_h_total_too_big
    $error("vga_timing_gen: H_TOTAL exceeds counter range");
  end
  if (V_TOTAL > CNT_LIMIT) begin : g_v_total_too_big
    $error("vga_timing_gen: V_TOTAL exceeds counter range");
  end

  logic [CNT_W-1:0] w_col_next;
  logic [CNT_W-1:0] w_row_next;
  logic             w_h_wrap;
  logic             w_v_wrap;
  vga_ctl_t         w_ctl_next;
  vga_ctl_t         r_ctl;

  wrap_counter #(
    .WIDTH    (CNT_W),
    .TERMINAL (H_TOTAL - 1)
  ) u_h_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_en         (1'b1),
    .o_count      (col),
    .o_count_next (w_col_next),
    .o_wrap       (w_h_wrap)
  );

  wrap_counter #(
    .WIDTH    (CNT_W),
    .TERMINAL (V_TOTAL - 1)
  ) u_v_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_en         (w_h_wrap),
    .o_count      (row),
    .o_count_next (w_row_next),
    .o_wrap       (w_v_wrap)
  );

  // Decode the upcoming position so the registered flags line up with col/row.
  // The vertical wrap fires exactly when the next position is (0,0).
  always_comb begin
    w_ctl_next             = '0;
    w_ctl_next.valid       = in_window(w_col_next, 0, H_ACTIVE) &&
                             in_window(w_row_next, 0, V_ACTIVE);
    w_ctl_next.hsync       = SYNC_IDLE ^ in_window(w_col_next, H_SYNC_LO, H_SYNC_HI);
    w_ctl_next.vsync       = SYNC_IDLE ^ in_window(w_row_next, V_SYNC_LO, V_SYNC_HI);
    w_ctl_next.frame_start = w_v_wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctl.valid       <= 1'b0;
      r_ctl.hsync       <= SYNC_IDLE;
      r_ctl.vsync       <= SYNC_IDLE;
      r_ctl.frame_start <= 1'b0;
    end else begin
      r_ctl <= w_ctl_next;
    end
  end

  assign valid       = r_ctl.valid;
  assign hsync       = r_ctl.hsync;
  assign vsync       = r_ctl.vsync;
  assign frame_start = r_ctl.frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized bench against a position-from-elapsed-clocks model
module tb_vga_timing_gen;

  logic       clk;
  logic       rst_n;

  logic       d_valid, d_hsync, d_vsync, d_fs;
  logic [9:0] d_col, d_row;
  logic       s_valid, s_hsync, s_vsync, s_fs;
  logic [9:0] s_col, s_row;

  int         n_checks = 0;
  int         n_errors = 0;
  longint     t        = 0;
  longint     g        = 0;
  longint     last_fs  = -1;

  localparam int S_HA = 8, S_HF = 2, S_HS = 3, S_HB = 2;
  localparam int S_VA = 5, S_VF = 2, S_VS = 2, S_VB = 3;
  localparam int S_FRAME = (S_HA + S_HF + S_HS + S_HB) * (S_VA + S_VF + S_VS + S_VB);

  vga_timing_gen u_dut_dflt (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid       (d_valid),
    .col         (d_col),
    .row         (d_row),
    .hsync       (d_hsync),
    .vsync       (d_vsync),
    .frame_start (d_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE (S_HA), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
    .V_ACTIVE (S_VA), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB),
    .SYNC_ACTIVE_LOW (0)
  ) u_dut_small (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid       (s_valid),
    .col         (s_col),
    .row         (s_row),
    .hsync       (s_hsync),
    .vsync       (s_vsync),
    .frame_start (s_fs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0d)", tag, got, exp, t);
    end
  endtask

  // Expected {valid,col,row,hsync,vsync,frame_start} after el clocks since reset release.
  function automatic logic [31:0] model(input int ha, hf, hs, hb, va, vf, vs, vb,
                                        input bit low, input longint el);
    int ht, vt, c, r;
    longint p;
    logic v, h, vy, fs;
    logic [9:0] c10, r10;
    ht  = ha + hf + hs + hb;
    vt  = va + vf + vs + vb;
    p   = el % longint'(ht * vt);
    c   = int'(p % ht);
    r   = int'(p / ht);
    v   = (el > 0) && (c < ha) && (r < va);
    h   = (c >= ha + hf) && (c < ha + hf + hs);
    vy  = (r >= va + vf) && (r < va + vf + vs);
    h   = low ? !h : h;
    vy  = low ? !vy : vy;
    fs  = (el > 0) && (p == 0);
    c10 = c[9:0];
    r10 = r[9:0];
    return {8'h0, v, c10, r10, h, vy, fs};
  endfunction

  function automatic logic [31:0] pack(input logic v, input logic [9:0] c, input logic [9:0] r,
                                       input logic h, input logic vy, input logic fs);
    return {8'h0, v, c, r, h, vy, fs};
  endfunction

  task automatic compare_all(input string sfx);
    check_eq({"dflt", sfx}, pack(d_valid, d_col, d_row, d_hsync, d_vsync, d_fs),
             model(640, 16, 96, 48, 480, 10, 2, 33, 1'b1, t));
    check_eq({"small", sfx}, pack(s_valid, s_col, s_row, s_hsync, s_vsync, s_fs),
             model(S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, 1'b0, t));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) t++;
    g++;
    @(negedge clk);
    compare_all("");
    if (s_fs) begin
      if (last_fs >= 0) check_eq("fs_period", 32'(g - last_fs), 32'(S_FRAME));
      last_fs = g;
    end
  endtask

  task automatic release_and_check();
    rst_n = 1'b1;
    tick();
    check_eq("first_col", 32'(d_col), 32'd1);
    check_eq("first_valid", 32'(d_valid), 32'd1);
    check_eq("first_row", 32'(d_row), 32'd0);
  endtask

  // Drop reset between edges and confirm outputs clear without a clock edge.
  task automatic async_reset();
    #2;
    rst_n   = 1'b0;
    t       = 0;
    last_fs = -1;
    #1;
    compare_all("_async");
    check_eq("async_hsync_dflt", 32'(d_hsync), 32'd1);
    check_eq("async_vsync_small", 32'(s_vsync), 32'd0);
    repeat (2) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    check_eq("rst_hsync_dflt", 32'(d_hsync), 32'd1);
    check_eq("rst_vsync_dflt", 32'(d_vsync), 32'd1);
    check_eq("rst_hsync_small", 32'(s_hsync), 32'd0);
    check_eq("rst_valid", 32'(d_valid), 32'd0);
    release_and_check();

    repeat (1700) tick();
    repeat (400) tick();

    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(1, 300)) tick();
      async_reset();
      release_and_check();
    end
    repeat ($urandom_range(200, 400)) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
